// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output gain ramp.
package audio_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned GAIN_W     = 9;
    localparam int unsigned GAIN_UNITY = 2 ** (GAIN_W - 1);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_HOLDOFF,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN,
        ST_MUTED
    } audio_state_e;

endpackage

// File: rtl/audio_gain_mul.sv
// Two-stage signed sample x unsigned gain multiply with floor shift back to sample width.
module audio_gain_mul
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned GAIN_BITS = 9
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        update,
    input  logic signed [WIDTH-1:0]     sample,
    input  logic        [GAIN_BITS-1:0] gain,
    output logic signed [WIDTH-1:0]     result
);

    localparam int unsigned PW = WIDTH + GAIN_BITS + 1;

    logic signed [WIDTH-1:0]     s1_sample;
    logic        [GAIN_BITS-1:0] s1_gain;
    logic signed [PW-1:0]        product;

    // Gain is zero-extended so the multiply stays signed; the shifted result always fits WIDTH.
    assign product = PW'(s1_sample) * PW'($signed({1'b0, s1_gain}));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_sample <= '0;
            s1_gain   <= '0;
            result    <= '0;
        end else begin
            if (load) begin
                s1_sample <= sample;
                s1_gain   <= gain;
            end
            if (update) begin
                result <= WIDTH'(product >>> (GAIN_BITS - 1));
            end
        end
    end

endmodule

// File: rtl/audio_out_ramp.sv
// Audio output stage: post-reset hold-off, click-free linear gain ramp, soft mute and DAC enable.
module audio_out_ramp
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned HOLDOFF   = 8388608,
    parameter int unsigned STEP_DIV  = 1024,
    parameter int unsigned GAIN_BITS = 9
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    mute_req,
    input  logic signed [WIDTH-1:0] in_l,
    input  logic signed [WIDTH-1:0] in_r,
    output logic signed [WIDTH-1:0] out_l,
    output logic signed [WIDTH-1:0] out_r,
    output logic                    out_valid,
    output logic                    dac_en,
    output logic                    muted
);

    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLDOFF - 1);
    localparam logic [SW-1:0]        STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [GAIN_BITS-1:0] GAIN_ONE  = GAIN_BITS'(1);
    localparam logic [GAIN_BITS-1:0] UNITY     = GAIN_ONE << (GAIN_BITS - 1);
    localparam logic [GAIN_BITS-1:0] UNITY_M1  = UNITY - GAIN_ONE;

    audio_state_e         state;
    logic [HW-1:0]        hold_cnt;
    logic [SW-1:0]        step_cnt;
    logic [GAIN_BITS-1:0] gain;
    logic                 load_d;

    // Controller: every state change, count and gain step happens on ce only.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_HOLDOFF;
            hold_cnt  <= '0;
            step_cnt  <= '0;
            gain      <= '0;
            load_d    <= 1'b0;
            out_valid <= 1'b0;
            dac_en    <= 1'b0;
            muted     <= 1'b1;
        end else begin
            load_d    <= ce;
            out_valid <= load_d;
            if (ce) begin
                muted <= 1'b0;
                case (state)
                    ST_HOLDOFF: begin
                        muted <= 1'b1;
                        if (hold_cnt == HOLD_LAST) begin
                            dac_en   <= 1'b1;
                            step_cnt <= '0;
                            state    <= mute_req ? ST_MUTED : ST_RAMP_UP;
                            muted    <= mute_req;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    ST_RAMP_UP: begin
                        if (mute_req) begin
                            state    <= ST_RAMP_DOWN;
                            step_cnt <= '0;
                        end else if (gain == UNITY) begin
                            state    <= ST_RUN;
                            step_cnt <= '0;
                        end else if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            gain     <= gain + GAIN_ONE;
                            if (gain == UNITY_M1) begin
                                state <= ST_RUN;
                            end
                        end else begin
                            step_cnt <= step_cnt + SW'(1);
                        end
                    end
                    ST_RUN: begin
                        gain <= UNITY;
                        if (mute_req) begin
                            state    <= ST_RAMP_DOWN;
                            step_cnt <= '0;
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (!mute_req) begin
                            state    <= ST_RAMP_UP;
                            step_cnt <= '0;
                        end else if (gain == '0) begin
                            state    <= ST_MUTED;
                            step_cnt <= '0;
                            muted    <= 1'b1;
                        end else if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            gain     <= gain - GAIN_ONE;
                            if (gain == GAIN_ONE) begin
                                state <= ST_MUTED;
                                muted <= 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt + SW'(1);
                        end
                    end
                    ST_MUTED: begin
                        gain  <= '0;
                        muted <= 1'b1;
                        if (!mute_req) begin
                            state    <= ST_RAMP_UP;
                            step_cnt <= '0;
                            muted    <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_HOLDOFF;
                        muted <= 1'b1;
                    end
                endcase
            end
        end
    end

    audio_gain_mul #(.WIDTH(WIDTH), .GAIN_BITS(GAIN_BITS)) u_mul_l (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (ce),
        .update  (load_d),
        .sample  (in_l),
        .gain    (gain),
        .result  (out_l)
    );

    audio_gain_mul #(.WIDTH(WIDTH), .GAIN_BITS(GAIN_BITS)) u_mul_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (ce),
        .update  (load_d),
        .sample  (in_r),
        .gain    (gain),
        .result  (out_r)
    );

endmodule

// File: tb/tb_audio_out_ramp.sv
// Directed bench for audio_out_ramp: hold-off, ramps, soft mute, arithmetic, reset and ce gating.
module tb_audio_out_ramp;
    import audio_pkg::*;

    logic    clk_sys;
    logic    reset;
    logic    ce;
    logic    mute_req;
    sample_t in_l;
    sample_t in_r;
    sample_t out_l;
    sample_t out_r;
    logic    out_valid;
    logic    dac_en;
    logic    muted;

    int   n_checks;
    int   n_fail;
    logic v1, v2, v3;

    typedef struct {
        logic        mute;
        logic [15:0] il;
        logic [15:0] ir;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t run_vec[4];
    vec_t half_vec[6];

    audio_out_ramp #(
        .WIDTH(16), .HOLDOFF(4), .STEP_DIV(2), .GAIN_BITS(9)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce        (ce),
        .mute_req  (mute_req),
        .in_l      (in_l),
        .in_r      (in_r),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .dac_en    (dac_en),
        .muted     (muted)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk_s(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // One ce tick followed by two idle clocks; entered and left 1 time unit after a rising edge.
    task automatic tick();
        ce = 1'b1;
        @(posedge clk_sys); #1 ce = 1'b0; v1 = out_valid;
        @(posedge clk_sys); #1 v2 = out_valid;
        @(posedge clk_sys); #1 v3 = out_valid;
    endtask

    // Ramp-up from gain 0 with the step counter cleared: expected gain seen by tick t.
    function automatic int up_gain(input int t);
        return (t < 2) ? 0 : (t - 2) / 2;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        n_checks = 0;
        n_fail   = 0;
        run_vec[0] = '{1'b0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        run_vec[1] = '{1'b0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        run_vec[2] = '{1'b0, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
        run_vec[3] = '{1'b0, 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC};
        half_vec[0] = '{1'b0, 16'h4000, 16'hC000, 16'h2000, 16'hE000};
        half_vec[1] = '{1'b1, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF};
        half_vec[2] = '{1'b0, 16'h0003, 16'h0001, 16'h0001, 16'h0000};
        half_vec[3] = '{1'b1, 16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF};
        half_vec[4] = '{1'b0, 16'h7FFF, 16'h0002, 16'h3FFF, 16'h0001};
        half_vec[5] = '{1'b1, 16'hFFFD, 16'h8001, 16'hFFFE, 16'hC000};

        reset = 1'b1; ce = 1'b0; mute_req = 1'b0;
        in_l = 16'h4000; in_r = 16'hC000;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_s("rst_out_l", out_l, 16'h0000);
        chk_s("rst_out_r", out_r, 16'h0000);
        chk_b("rst_valid", out_valid, 1'b0);
        chk_b("rst_dac_en", dac_en, 1'b0);
        chk_b("rst_muted", muted, 1'b1);
        reset = 1'b0;

        for (int t = 1; t <= 4; t++) begin
            tick();
            chk_s("hold_out_l", out_l, 16'h0000);
            chk_b("hold_dac_en", dac_en, t == 4);
            chk_b("hold_muted", muted, t < 4);
        end

        for (int r = 1; r <= 512; r++) begin
            tick();
            chk_s("ramp_up_l", out_l, 16'(64 * ((r - 1) / 2)));
            chk_s("ramp_up_r", out_r, 16'(-64 * ((r - 1) / 2)));
        end
        tick();
        chk_s("unity_l", out_l, 16'h4000);
        chk_s("unity_r", out_r, 16'hC000);
        chk_b("run_dac_en", dac_en, 1'b1);
        chk_b("run_muted", muted, 1'b0);

        foreach (run_vec[i]) begin
            mute_req = run_vec[i].mute;
            in_l = run_vec[i].il;
            in_r = run_vec[i].ir;
            tick();
            chk_s("run_vec_l", out_l, run_vec[i].el);
            chk_s("run_vec_r", out_r, run_vec[i].er);
            chk_b("run_valid_ce_edge", v1, 1'b0);
            chk_b("run_valid_2clk", v2, 1'b1);
            chk_b("run_valid_3clk", v3, 1'b0);
        end

        // Ramp down from unity to gain 128, then hold it there by toggling mute every tick.
        in_l = 16'h4000; in_r = 16'hC000; mute_req = 1'b1;
        repeat (257) tick();
        foreach (half_vec[i]) begin
            mute_req = half_vec[i].mute;
            in_l = half_vec[i].il;
            in_r = half_vec[i].ir;
            tick();
            chk_s("half_vec_l", out_l, half_vec[i].el);
            chk_s("half_vec_r", out_r, half_vec[i].er);
        end

        in_l = 16'h4000; in_r = 16'hC000; mute_req = 1'b1;
        for (int t = 1; t <= 256; t++) begin
            tick();
            chk_s("down128_l", out_l, 16'(64 * (128 - (t - 1) / 2)));
            chk_b("down128_muted", muted, t == 256);
        end
        repeat (3) begin
            tick();
            chk_s("muted_out_l", out_l, 16'h0000);
            chk_b("muted_dac_en", dac_en, 1'b1);
        end

        mute_req = 1'b0;
        for (int t = 1; t <= 201; t++) begin
            tick();
            chk_s("up100_l", out_l, 16'(64 * up_gain(t)));
            chk_b("up100_muted", muted, 1'b0);
        end

        mute_req = 1'b1;
        for (int t = 1; t <= 201; t++) begin
            tick();
            chk_s("down100_l", out_l, 16'(64 * ((t < 2) ? 100 : 100 - (t - 2) / 2)));
            chk_b("down100_muted", muted, t == 201);
        end
        repeat (2) begin
            tick();
            chk_s("down100_zero_l", out_l, 16'h0000);
            chk_s("down100_zero_r", out_r, 16'h0000);
            chk_b("down100_dac_en", dac_en, 1'b1);
            chk_b("down100_muted_hold", muted, 1'b1);
        end

        mute_req = 1'b0;
        for (int t = 1; t <= 101; t++) begin
            tick();
            chk_s("up50_l", out_l, 16'(64 * up_gain(t)));
        end
        mute_req = 1'b1;
        tick();
        chk_s("down50_l", out_l, 16'h0C80);

        // Reset lands one clock after a ce tick, mid ramp-down, with mute still requested.
        ce = 1'b1;
        @(posedge clk_sys); #1 ce = 1'b0; reset = 1'b1;
        @(posedge clk_sys); #1;
        chk_s("midrst_out_l", out_l, 16'h0000);
        chk_s("midrst_out_r", out_r, 16'h0000);
        chk_b("midrst_valid", out_valid, 1'b0);
        chk_b("midrst_dac_en", dac_en, 1'b0);
        chk_b("midrst_muted", muted, 1'b1);
        @(posedge clk_sys); #1 reset = 1'b0;

        for (int t = 1; t <= 4; t++) begin
            tick();
            chk_s("rehold_out_l", out_l, 16'h0000);
            chk_b("rehold_dac_en", dac_en, t == 4);
            chk_b("rehold_muted", muted, 1'b1);
        end
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk_s("mute_held_out_l", out_l, 16'h0000);
            chk_b("mute_held_muted", muted, 1'b1);
            chk_b("mute_held_dac_en", dac_en, 1'b1);
        end

        mute_req = 1'b0;
        repeat (5) tick();
        chk_s("pre_idle_l", out_l, 16'h0040);

        // ce idle for 1000 clocks while inputs and mute_req wiggle.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            mute_req = i[0];
            in_l = (i[1]) ? 16'h7FFF : 16'h8000;
            @(posedge clk_sys); #1;
            if (out_l !== 16'h0040 || out_r !== 16'hFFC0 || out_valid !== 1'b0 ||
                dac_en !== 1'b1 || muted !== 1'b0) begin
                bad++;
            end
        end
        chk_s("ce_low_hold", 16'(bad), 16'h0000);
        mute_req = 1'b0; in_l = 16'h4000;
        tick();
        chk_s("resume_l_a", out_l, 16'h0080);
        tick();
        chk_s("resume_l_b", out_l, 16'h0080);
        tick();
        chk_s("resume_l_c", out_l, 16'h00C0);
        chk_s("resume_r_c", out_r, 16'hFF40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_out_ramp.md
Name: audio_out_ramp

Overview:
- Sits between the tsconf core's SOUND_L/SOUND_R outputs and the audio sinks: dac_dsm2v pair, i2s, spdif.
- Replaces the plain mute counter with a post-reset hold-off followed by a click-free linear gain ramp.
- Provides a runtime soft-mute request and a DAC-enable that drives the AUDIO_L/AUDIO_R tristate.
- Registers samples on the 28 MHz clock enable and emits one valid strobe per processed sample.

Parameters:
WIDTH, 16, sample width; signed two's complement
HOLDOFF, 8388608, ce ticks of silence after reset before ramp-up starts; must be >= 1
STEP_DIV, 1024, ce ticks per gain step; must be >= 1
GAIN_BITS, 9, gain register width; unity gain = 2**(GAIN_BITS-1) = 256

Ports:
clk_sys  in  1  system clock (84 MHz)
reset  in  1  synchronous, active-high reset
ce  in  1  28 MHz clock enable; processing advances only on ce=1
mute_req  in  1  level; 1 = ramp to silence, 0 = ramp to unity
in_l  in  WIDTH  left sample, signed
in_r  in  WIDTH  right sample, signed
out_l  out  WIDTH  scaled left sample, signed
out_r  out  WIDTH  scaled right sample, signed
out_valid  out  1  one-clk_sys pulse when out_l/out_r update
dac_en  out  1  1 = drive DAC pins; 0 = tristate
muted  out  1  1 when gain==0 and state is HOLDOFF or MUTED

Behaviour:
- Reset (synchronous, active-high, any cycle including mid-ramp):
  - state=HOLDOFF, gain=0, holdoff counter=0, step counter=0.
  - out_l=out_r=0, out_valid=0, dac_en=0, muted=1.
- Clock enable: all counters, gain changes and sample captures occur only on clk_sys edges with ce=1. ce=0 holds all state; out_valid=0 on those cycles.
- Datapath, 2-stage pipeline:
  - Stage 1 on a ce cycle: latch in_l/in_r and the current gain.
  - Stage 2, next clk_sys cycle: out = (in * gain) >>> (GAIN_BITS-1).
  - Signed WIDTH x unsigned GAIN_BITS multiply into WIDTH+GAIN_BITS bits; arithmetic shift truncates toward -inf; the result always fits WIDTH, so no saturation is needed.
  - gain=256 is exact pass-through. gain=0 gives 0.
  - out_valid pulses together with stage-2 update, i.e. 2 clk_sys cycles after the ce cycle that latched the sample.
- State machine (evaluated on ce):
  - HOLDOFF: increment holdoff counter. On reaching HOLDOFF-1 go to MUTED if mute_req=1, else RAMP_UP. dac_en asserts on leaving HOLDOFF and stays 1 until the next reset.
  - RAMP_UP: step counter counts 0..STEP_DIV-1. On wrap, gain += 1. At gain==256 go to RUN.
    - mute_req=1 goes to RAMP_DOWN immediately, keeping the current gain; the step counter is cleared.
  - RUN: gain fixed at 256. mute_req=1 goes to RAMP_DOWN with the step counter cleared.
  - RAMP_DOWN: same stepping, gain -= 1. At gain==0 go to MUTED.
    - mute_req=0 goes to RAMP_UP with the current gain kept and the step counter cleared.
  - MUTED: gain=0, outputs 0, dac_en stays 1 so the pins do not pop. mute_req=0 goes to RAMP_UP.
- Gain never wraps: it saturates at 0 and 256. A full ramp takes 256*STEP_DIV ce ticks.
- mute_req is sampled on ce only. A toggle shorter than one ce period is ignored.
- Simultaneous events:
  - Holdoff expiry together with mute_req=1 goes to MUTED.
  - A step wrap on the same tick as a direction change: the direction change wins and gain is unchanged that tick.
- muted=1 exactly when (state==HOLDOFF or state==MUTED) and gain==0.

Decomposition:
- Shared package audio_pkg holds:
  - the state enum (HOLDOFF, RAMP_UP, RUN, RAMP_DOWN, MUTED);
  - GAIN_UNITY localparam;
  - a sample typedef: logic signed [WIDTH-1:0].
- Sub-module audio_gain_mul: the 2-stage signed multiply/shift, instantiated once per channel.
- The controller FSM and counters stay in audio_out_ramp.

Test Plan:
- Use HOLDOFF=4, STEP_DIV=2, ce every 3rd clk, in_l=16'h4000, in_r=16'hC000. After reset release:
  - out=0 and dac_en=0 for 4 ce ticks;
  - dac_en=1 on the 5th tick;
  - gain reaches 256 after 512 further ticks;
  - out_l=16'h4000, out_r=16'hC000.
- In RUN with in_l=16'h7FFF: out_valid exactly 2 clk after each ce, once per ce; out_l=16'h7FFF; in_l=16'h8000 gives out_l=16'h8000.
- Arithmetic at gain=128 (stop ramp via mute_req toggling): in_l=16'hFFFF -> out_l=16'hFFFF (floor of -0.5); in_l=16'h0003 -> 16'h0001.
- mute_req=1 at gain=100 during RAMP_UP: gain descends 100->0 over 200 ce ticks; then muted=1, out=0, dac_en stays 1. mute_req=0 then ramps back up.
- Reset asserted mid-RAMP_DOWN (gain=50): next clk out=0, out_valid=0, dac_en=0, muted=1, and the hold-off restarts from 0.
- Boundaries:
  - mute_req=1 held through reset: after hold-off the state is MUTED, gain never leaves 0, dac_en=1.
  - ce held low 1000 clk: no state or output change.
